pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst  in  1  synchronous, active-high reset (1 = reset).
REQ-003 SHALL have ports: stallreq_id  in  1  load-use hazard request from ID.
REQ-004 SHALL have ports: stallreq_ex  in  1  generic EX hold request (level).
REQ-005 SHALL have ports: mdu_start  in  1  one-cycle pulse, EX begins multi-cycle op.
REQ-006 SHALL have ports: mdu_len  in  6  EX busy cycles for the op started by mdu_start; 0 means no hold.
REQ-007 SHALL have ports: excptype_i  in  32  exception vector from MEM. Bit0 interrupt, bit8 syscall, bit9 reserved instruction, bit10 overflow, bit12 eret.
REQ-008 SHALL have ports: pc_i  in  32  PC of the instruction in MEM.
REQ-009 SHALL have ports: epc_i  in  32  current CP0 EPC value.
REQ-010 SHALL have ports: stall  out  6  per-stage hold. Bit0 PC, 1 IF_ID, 2 ID_EX, 3 EX_MEM, 4 MEM_WB, 5 WB; 1 = Stop.
REQ-011 SHALL have ports: flush  out  1  clears all pipeline registers.
REQ-012 SHALL have ports: new_pc  out  32  redirect target, valid while flush=1.
REQ-013 SHALL have ports: epc_we, epc_o, cause_o  out  1/32/5  CP0 EPC/Cause write port.
REQ-014 SHALL have parameter: HANDLER_ADDR, default 32'h0000_0020, exception entry point.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY, FLUSH; all outputs are registered.
REQ-016 In IDLE, with no exception and no request, SHALL drive stall=6'b000000 and flush=0.
REQ-017 stallreq_id=1 with no exception and not BUSY SHALL drive stall=6'b000111 on the next cycle, so ID_EX receives a bubble.
REQ-018 stallreq_ex=1 SHALL drive stall=6'b001111 on the next cycle; this takes precedence over stallreq_id.
REQ-019 mdu_start with mdu_len=N>0 SHALL enter BUSY, load a counter with N and drive stall=6'b001111 for exactly N cycles, starting the next cycle.
REQ-020 mdu_len=0 SHALL leave the FSM in IDLE.
REQ-021 In BUSY, the counter SHALL decrement each cycle and return to IDLE on the cycle it reaches 0.
REQ-022 In BUSY, mdu_start SHALL be ignored.
REQ-023 Exception detect: excptype_i != 0, evaluated in any state. Detection SHALL enter FLUSH and abort any BUSY countdown; the counter is cleared.
REQ-024 In FLUSH, SHALL hold flush=1 and stall=6'b000000 for exactly one cycle, then return to IDLE.
REQ-025 Exception priority SHALL be interrupt > syscall > reserved instruction > overflow > eret.
REQ-026 Exception codes SHALL be: interrupt 0, syscall 8, reserved instruction 10, overflow 12.
REQ-027 On a non-eret exception, SHALL set new_pc=HANDLER_ADDR, epc_we=1, epc_o=pc_i and cause_o to the code, all for the FLUSH cycle.
REQ-028 On eret, SHALL set new_pc=epc_i, epc_we=0 and cause_o=0.
REQ-029 A new exception arriving in the FLUSH cycle SHALL be ignored, because MEM is being flushed.
REQ-030 Simultaneous exception and stall or mdu requests SHALL treat the exception as winning and drop the stall request.
REQ-031 Outside FLUSH, new_pc, epc_o and cause_o SHALL be 0, and epc_we and flush SHALL be 0.

Reset
REQ-032 On rst=1 at a clock edge, SHALL set state=IDLE, counter=0, stall=6'b000000, flush=0, new_pc=0, epc_we=0, epc_o=0, cause_o=0.
REQ-033 Reset SHALL take priority over every input, including mid-BUSY and mid-FLUSH.
REQ-034 The first cycle after reset release SHALL behave as IDLE.

Verification
REQ-035 Bench SHALL cover: stallreq_id=1 for 1 cycle -> stall=6'b000111 for exactly one cycle, then 6'b000000.
REQ-036 Bench SHALL cover: mdu_start, mdu_len=5 -> stall=6'b001111 for 5 consecutive cycles, then IDLE; a second mdu_start during BUSY changes nothing.
REQ-037 Bench SHALL cover: excptype_i=32'h400 (overflow), pc_i=32'h0000_1004, 3 cycles into a mdu_len=8 hold -> next cycle flush=1, stall=0, new_pc=32'h20, epc_we=1, epc_o=32'h1004, cause_o=12; following cycle IDLE, no residual stall.
REQ-038 Bench SHALL cover: excptype_i=32'h1101 (interrupt+syscall+eret) -> cause_o=0, new_pc=32'h20.
REQ-039 Bench SHALL cover: excptype_i=32'h1000, epc_i=32'h0000_2000 -> flush=1, new_pc=32'h2000, epc_we=0.
REQ-040 Bench SHALL cover: rst=1 asserted during BUSY with stallreq_ex=1 -> next cycle all outputs 0, state IDLE.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/exception controller: per-stage stall vector, multi-cycle EX holds,
// and one-cycle flush with CP0 EPC/Cause update on exceptions taken in MEM.
module pipe_ctrl #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0020
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        mdu_start,
    input  logic [5:0]  mdu_len,
    input  logic [31:0] excptype_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        epc_we,
    output logic [31:0] epc_o,
    output logic [4:0]  cause_o
);

    typedef enum logic [1:0] {IDLE, BUSY, FLUSH} state_t;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;

    state_t      state, state_nxt;
    logic [5:0]  cnt, cnt_nxt, cnt_dec;
    logic [5:0]  stall_nxt, req_stall;
    logic        flush_nxt, epc_we_nxt;
    logic [31:0] new_pc_nxt, epc_o_nxt;
    logic [4:0]  cause_nxt;
    logic [5:0]  exc_info;

    // Returns {is_eret, cause}; lower-numbered causes win.
    function automatic logic [5:0] exc_decode(input logic [31:0] e);
        if (e[0])       return {1'b0, 5'd0};
        else if (e[8])  return {1'b0, 5'd8};
        else if (e[9])  return {1'b0, 5'd10};
        else if (e[10]) return {1'b0, 5'd12};
        else if (e[12]) return {1'b1, 5'd0};
        else            return {1'b0, 5'd0};
    endfunction

    assign exc_info  = exc_decode(excptype_i);
    assign cnt_dec   = cnt - 6'd1;
    assign req_stall = stallreq_ex ? STALL_EX : (stallreq_id ? STALL_ID : STALL_NONE);

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        stall_nxt  = STALL_NONE;
        flush_nxt  = 1'b0;
        new_pc_nxt = 32'd0;
        epc_we_nxt = 1'b0;
        epc_o_nxt  = 32'd0;
        cause_nxt  = 5'd0;
        case (state)
            FLUSH: begin
                // MEM is being flushed, so anything arriving now is discarded.
                state_nxt = IDLE;
            end
            default: begin
                if (excptype_i != 32'd0) begin
                    state_nxt = FLUSH;
                    cnt_nxt   = 6'd0;
                    flush_nxt = 1'b1;
                    if (exc_info[5]) begin
                        new_pc_nxt = epc_i;
                    end else begin
                        new_pc_nxt = HANDLER_ADDR;
                        epc_we_nxt = 1'b1;
                        epc_o_nxt  = pc_i;
                        cause_nxt  = exc_info[4:0];
                    end
                end else if (state == BUSY) begin
                    cnt_nxt = cnt_dec;
                    if (cnt_dec == 6'd0) begin
                        state_nxt = IDLE;
                        stall_nxt = req_stall;
                    end else begin
                        stall_nxt = STALL_EX;
                    end
                end else if (mdu_start && (mdu_len != 6'd0)) begin
                    state_nxt = BUSY;
                    cnt_nxt   = mdu_len;
                    stall_nxt = STALL_EX;
                end else begin
                    stall_nxt = req_stall;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 6'd0;
            stall   <= STALL_NONE;
            flush   <= 1'b0;
            new_pc  <= 32'd0;
            epc_we  <= 1'b0;
            epc_o   <= 32'd0;
            cause_o <= 5'd0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            stall   <= stall_nxt;
            flush   <= flush_nxt;
            new_pc  <= new_pc_nxt;
            epc_we  <= epc_we_nxt;
            epc_o   <= epc_o_nxt;
            cause_o <= cause_nxt;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus randomized traffic against a cycle-level model.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_id, stallreq_ex, mdu_start;
    logic [5:0]  mdu_len;
    logic [31:0] excptype_i, pc_i, epc_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        epc_we;
    logic [31:0] epc_o;
    logic [4:0]  cause_o;

    int checks = 0;
    int failures = 0;

    pipe_ctrl #(.HANDLER_ADDR(32'h0000_0020)) dut (
        .clk(clk), .rst(rst),
        .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
        .mdu_start(mdu_start), .mdu_len(mdu_len),
        .excptype_i(excptype_i), .pc_i(pc_i), .epc_i(epc_i),
        .stall(stall), .flush(flush), .new_pc(new_pc),
        .epc_we(epc_we), .epc_o(epc_o), .cause_o(cause_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rst = 1'b0; stallreq_id = 1'b0; stallreq_ex = 1'b0; mdu_start = 1'b0;
        mdu_len = 6'd0; excptype_i = 32'd0; pc_i = 32'd0; epc_i = 32'd0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        tick(); tick();
        checks++;
        if ({stall, flush, new_pc, epc_we, epc_o, cause_o} !== 77'd0) begin
            failures++;
            $display("FAIL reset_outputs stall=%b flush=%b new_pc=%h epc_we=%b epc_o=%h cause=%0d required all zero",
                     stall, flush, new_pc, epc_we, epc_o, cause_o);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (stall !== 6'b000000 || flush !== 1'b0) begin
            failures++;
            $display("FAIL reset_release stall=%b flush=%b required 000000/0", stall, flush);
        end
    endtask

    task automatic test_stall_id();
        stallreq_id = 1'b1;
        tick();
        stallreq_id = 1'b0;
        checks++;
        if (stall !== 6'b000111) begin
            failures++; $display("FAIL id_stall stall=%b required 000111", stall);
        end
        tick();
        checks++;
        if (stall !== 6'b000000) begin
            failures++; $display("FAIL id_stall_release stall=%b required 000000", stall);
        end
        stallreq_id = 1'b1; stallreq_ex = 1'b1;
        tick();
        stallreq_id = 1'b0; stallreq_ex = 1'b0;
        checks++;
        if (stall !== 6'b001111) begin
            failures++; $display("FAIL ex_over_id stall=%b required 001111", stall);
        end
        tick();
    endtask

    task automatic test_mdu();
        mdu_start = 1'b1; mdu_len = 6'd5;
        tick();
        mdu_start = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            checks++;
            if (stall !== 6'b001111) begin
                failures++; $display("FAIL mdu_hold cycle=%0d stall=%b required 001111", i, stall);
            end
            mdu_start = (i == 2);
            mdu_len   = 6'd9;
            tick();
        end
        mdu_start = 1'b0;
        checks++;
        if (stall !== 6'b000000) begin
            failures++; $display("FAIL mdu_end stall=%b required 000000", stall);
        end
        tick();
        checks++;
        if (stall !== 6'b000000) begin
            failures++; $display("FAIL mdu_restart_ignored stall=%b required 000000", stall);
        end
        mdu_start = 1'b1; mdu_len = 6'd0;
        tick();
        mdu_start = 1'b0;
        checks++;
        if (stall !== 6'b000000) begin
            failures++; $display("FAIL mdu_len_zero stall=%b required 000000", stall);
        end
    endtask

    task automatic test_overflow_in_busy();
        mdu_start = 1'b1; mdu_len = 6'd8;
        tick();
        mdu_start = 1'b0;
        tick(); tick();
        excptype_i = 32'h400; pc_i = 32'h0000_1004; stallreq_ex = 1'b1;
        tick();
        excptype_i = 32'd0; pc_i = 32'd0; stallreq_ex = 1'b0;
        checks++;
        if (flush !== 1'b1 || stall !== 6'd0 || new_pc !== 32'h20 || epc_we !== 1'b1 ||
            epc_o !== 32'h1004 || cause_o !== 5'd12) begin
            failures++;
            $display("FAIL overflow_flush flush=%b stall=%b new_pc=%h epc_we=%b epc_o=%h cause=%0d required 1/000000/20/1/1004/12",
                     flush, stall, new_pc, epc_we, epc_o, cause_o);
        end
        tick();
        checks++;
        if ({stall, flush, new_pc, epc_we, epc_o, cause_o} !== 77'd0) begin
            failures++;
            $display("FAIL overflow_after stall=%b flush=%b new_pc=%h epc_we=%b required all zero",
                     stall, flush, new_pc, epc_we);
        end
        tick();
        checks++;
        if (stall !== 6'd0) begin
            failures++; $display("FAIL overflow_no_residual stall=%b required 000000", stall);
        end
    endtask

    task automatic test_priority();
        logic [31:0] vecs [5] = '{32'h1101, 32'h300, 32'h600, 32'h1400, 32'h100};
        logic [4:0]  codes[5] = '{5'd0, 5'd8, 5'd10, 5'd12, 5'd8};
        for (int i = 0; i < 5; i++) begin
            excptype_i = vecs[i]; pc_i = 32'h0000_3000 + 32'(i * 4); epc_i = 32'h0000_7777;
            tick();
            excptype_i = 32'd0;
            checks++;
            if (cause_o !== codes[i] || new_pc !== 32'h20 || epc_we !== 1'b1 || epc_o !== pc_i) begin
                failures++;
                $display("FAIL priority vec=%h cause=%0d new_pc=%h epc_we=%b epc_o=%h required cause=%0d new_pc=20 epc_we=1 epc_o=%h",
                         vecs[i], cause_o, new_pc, epc_we, epc_o, codes[i], pc_i);
            end
            tick();
        end
    endtask

    task automatic test_eret();
        excptype_i = 32'h1000; epc_i = 32'h0000_2000; pc_i = 32'h0000_5555;
        tick();
        checks++;
        if (flush !== 1'b1 || new_pc !== 32'h2000 || epc_we !== 1'b0 || cause_o !== 5'd0) begin
            failures++;
            $display("FAIL eret flush=%b new_pc=%h epc_we=%b cause=%0d required 1/2000/0/0",
                     flush, new_pc, epc_we, cause_o);
        end
        // exception still present during the flush cycle must be ignored
        excptype_i = 32'h400;
        tick();
        excptype_i = 32'd0;
        checks++;
        if (flush !== 1'b0 || new_pc !== 32'd0) begin
            failures++;
            $display("FAIL flush_ignores_new flush=%b new_pc=%h required 0/0", flush, new_pc);
        end
        tick();
    endtask

    task automatic test_reset_in_busy();
        mdu_start = 1'b1; mdu_len = 6'd8;
        tick();
        mdu_start = 1'b0;
        tick();
        stallreq_ex = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; stallreq_ex = 1'b0;
        checks++;
        if ({stall, flush, new_pc, epc_we, epc_o, cause_o} !== 77'd0) begin
            failures++;
            $display("FAIL reset_in_busy stall=%b flush=%b new_pc=%h required all zero", stall, flush, new_pc);
        end
        stallreq_id = 1'b1;
        tick();
        stallreq_id = 1'b0;
        checks++;
        if (stall !== 6'b000111) begin
            failures++; $display("FAIL reset_in_busy_idle stall=%b required 000111", stall);
        end
        tick();
    endtask

    task automatic test_random();
        bit          m_busy, m_flush;
        int          m_rem;
        logic [5:0]  e_stall;
        logic        e_flush, e_we;
        logic [31:0] e_pc, e_epc;
        logic [4:0]  e_cause;
        int          bitpos[5] = '{0, 8, 9, 10, 12};
        int          bcode [5] = '{0, 8, 10, 12, -1};
        int          sel;
        m_busy = 0; m_flush = 0; m_rem = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            rst         = (cyc == 0) || ($urandom_range(0, 49) == 0);
            stallreq_id = ($urandom_range(0, 3) == 0);
            stallreq_ex = ($urandom_range(0, 6) == 0);
            mdu_start   = ($urandom_range(0, 4) == 0);
            mdu_len     = 6'($urandom_range(0, 12));
            pc_i        = $urandom;
            epc_i       = $urandom;
            excptype_i  = 32'd0;
            if ($urandom_range(0, 9) == 0)
                while (excptype_i == 32'd0)
                    for (int b = 0; b < 5; b++)
                        if ($urandom_range(0, 1) == 1) excptype_i[bitpos[b]] = 1'b1;

            e_stall = 6'd0; e_flush = 1'b0; e_we = 1'b0; e_pc = 32'd0; e_epc = 32'd0; e_cause = 5'd0;
            if (rst) begin
                m_busy = 0; m_rem = 0; m_flush = 0;
            end else if (m_flush) begin
                m_flush = 0;
            end else if (excptype_i != 32'd0) begin
                m_flush = 1; m_busy = 0; m_rem = 0; e_flush = 1'b1;
                sel = 0;
                while (excptype_i[bitpos[sel]] !== 1'b1) sel++;
                if (bcode[sel] < 0) begin
                    e_pc = epc_i;
                end else begin
                    e_pc = 32'h20; e_we = 1'b1; e_epc = pc_i; e_cause = 5'(bcode[sel]);
                end
            end else if (m_busy && m_rem > 0) begin
                m_rem--; e_stall = 6'b001111;
            end else if (!m_busy && mdu_start && mdu_len > 0) begin
                m_busy = 1; m_rem = int'(mdu_len) - 1; e_stall = 6'b001111;
            end else begin
                m_busy = 0;
                e_stall = stallreq_ex ? 6'b001111 : (stallreq_id ? 6'b000111 : 6'b000000);
            end

            tick();
            checks++;
            if ({stall, flush, new_pc, epc_we, epc_o, cause_o} !== {e_stall, e_flush, e_pc, e_we, e_epc, e_cause}) begin
                failures++;
                $display("FAIL random cyc=%0d stall=%b flush=%b new_pc=%h we=%b epc=%h cause=%0d required %b/%b/%h/%b/%h/%0d",
                         cyc, stall, flush, new_pc, epc_we, epc_o, cause_o,
                         e_stall, e_flush, e_pc, e_we, e_epc, e_cause);
            end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_stall_id();
        test_mdu();
        test_overflow_in_busy();
        test_priority();
        test_eret();
        test_reset_in_busy();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
